// File: rtl/lfsr_stream_decrypt.sv
// LFSR stream decrypter: identifies the keystream tap pattern from a known preamble,
// then decrypts the message, strips the leading preamble and writes the payload.
module lfsr_stream_decrypt #(
    parameter int                 W        = 8,
    parameter int                 LW       = 6,
    parameter int                 NTAP     = 6,
    parameter logic [NTAP*LW-1:0] TAPS     = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
    parameter logic [W-1:0]       PRE_CHAR = 8'h5F,
    parameter int                 PRE_LEN  = 7,
    parameter int                 MSG_LEN  = 64,
    parameter int                 SRC_BASE = 64,
    parameter int                 DST_BASE = 0,
    parameter int                 AW       = 8
) (
    input  logic                     clk,
    input  logic                     init_n,
    input  logic                     start,
    output logic [AW-1:0]            rd_addr,
    input  logic [W-1:0]             rd_data,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [W-1:0]             wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [NTAP-1:0]          found,
    output logic [$clog2(NTAP)-1:0]  found_idx,
    output logic                     err_nomatch,
    output logic                     ambig,
    output logic [AW-1:0]            strip_ct,
    output logic [AW-1:0]            wr_ct
);

    localparam int IW = $clog2(NTAP);
    localparam int CW = $clog2(MSG_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_TRAIN, S_RUN, S_FIN} state_t;

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s, input logic [LW-1:0] tap);
        return {s[LW-2:0], ^(s & tap)};
    endfunction

    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [NTAP-1:0]    found_q, found_d;
    logic [IW-1:0]      found_idx_q, found_idx_d;
    logic               err_q, err_d, ambig_q, ambig_d;
    logic [AW-1:0]      strip_ct_q, strip_ct_d, wr_ct_q, wr_ct_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               iss_q, iss_d, rd_vld_q, rd_vld_d;
    logic [CW-1:0]      iss_ct_q, iss_ct_d, cons_ct_q, cons_ct_d;
    logic [NTAP-1:0]    surv_q, surv_d;
    logic [NTAP*LW-1:0] lfsr_q, lfsr_d;
    logic               paying_q, paying_d;
    logic               wr_en_q, wr_en_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [W-1:0]       wr_data_q, wr_data_d;

    // obs_key is the keystream value implied by assuming the current symbol is preamble.
    logic [LW-1:0]      obs_key;
    logic [NTAP*LW-1:0] seed_step, cur_step;
    logic [NTAP-1:0]    miss, surv_new, sel_onehot;
    logic               multi;
    logic [IW-1:0]      sel_idx;
    logic [LW-1:0]      sel_key;
    logic [W-1:0]       plain;

    assign obs_key = rd_data[LW-1:0] ^ PRE_CHAR[LW-1:0];

    for (genvar gi = 0; gi < NTAP; gi++) begin : g_cand
        assign seed_step[gi*LW +: LW] = lfsr_step(obs_key, TAPS[gi*LW +: LW]);
        assign cur_step[gi*LW +: LW]  = lfsr_step(lfsr_q[gi*LW +: LW], TAPS[gi*LW +: LW]);
        assign miss[gi]               = (obs_key != lfsr_q[gi*LW +: LW]);
    end

    assign surv_new   = surv_q & ~miss;
    assign sel_onehot = surv_new & (~surv_new + NTAP'(1));
    assign multi      = |(surv_new & (surv_new - NTAP'(1)));

    always_comb begin
        sel_idx = '0;
        for (int i = NTAP - 1; i >= 0; i--) begin
            if (surv_new[i]) sel_idx = IW'(i);
        end
    end

    always_comb begin
        sel_key = '0;
        for (int i = 0; i < NTAP; i++) begin
            if (found_q[i]) sel_key = lfsr_q[i*LW +: LW];
        end
    end

    assign plain = rd_data ^ W'(sel_key);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        found_idx_d = found_idx_q;
        err_d       = err_q;
        ambig_d     = ambig_q;
        strip_ct_d  = strip_ct_q;
        wr_ct_d     = wr_ct_q;
        rd_addr_d   = rd_addr_q;
        iss_d       = iss_q;
        iss_ct_d    = iss_ct_q;
        rd_vld_d    = iss_q;
        cons_ct_d   = cons_ct_q;
        surv_d      = surv_q;
        lfsr_d      = lfsr_q;
        paying_d    = paying_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        // Read issue runs free of the FSM: one address per cycle, MSG_LEN in total.
        if (iss_q) begin
            if (iss_ct_q == CW'(MSG_LEN)) begin
                iss_d = 1'b0;
            end else begin
                rd_addr_d = rd_addr_q + AW'(1);
                iss_ct_d  = iss_ct_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    found_d     = '0;
                    found_idx_d = '0;
                    err_d       = 1'b0;
                    ambig_d     = 1'b0;
                    strip_ct_d  = '0;
                    wr_ct_d     = '0;
                    rd_addr_d   = AW'(SRC_BASE);
                    iss_d       = 1'b1;
                    iss_ct_d    = CW'(1);
                    rd_vld_d    = 1'b0;
                    cons_ct_d   = '0;
                    paying_d    = 1'b0;
                    state_d     = S_SEED;
                end
            end
            S_SEED: begin
                if (rd_vld_q) begin
                    lfsr_d    = seed_step;
                    surv_d    = '1;
                    cons_ct_d = CW'(1);
                    state_d   = S_TRAIN;
                end
            end
            S_TRAIN: begin
                if (rd_vld_q) begin
                    lfsr_d    = cur_step;
                    surv_d    = surv_new;
                    cons_ct_d = cons_ct_q + CW'(1);
                    if (cons_ct_q == CW'(PRE_LEN - 1)) begin
                        if (surv_new == '0) begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            iss_d   = 1'b0;
                            state_d = S_FIN;
                        end else begin
                            found_d     = sel_onehot;
                            found_idx_d = sel_idx;
                            ambig_d     = multi;
                            strip_ct_d  = AW'(PRE_LEN);
                            state_d     = S_RUN;
                        end
                    end
                end
            end
            S_RUN: begin
                if (cons_ct_q == CW'(MSG_LEN)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (rd_vld_q) begin
                    lfsr_d    = cur_step;
                    cons_ct_d = cons_ct_q + CW'(1);
                    if (!paying_q && plain == PRE_CHAR) begin
                        strip_ct_d = strip_ct_q + AW'(1);
                    end else begin
                        paying_d  = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = AW'(DST_BASE) + wr_ct_q;
                        wr_data_d = plain;
                        wr_ct_d   = wr_ct_q + AW'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= '0;
            found_idx_q <= '0;
            err_q       <= 1'b0;
            ambig_q     <= 1'b0;
            strip_ct_q  <= '0;
            wr_ct_q     <= '0;
            rd_addr_q   <= '0;
            iss_q       <= 1'b0;
            iss_ct_q    <= '0;
            rd_vld_q    <= 1'b0;
            cons_ct_q   <= '0;
            surv_q      <= '0;
            lfsr_q      <= '0;
            paying_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            found_idx_q <= found_idx_d;
            err_q       <= err_d;
            ambig_q     <= ambig_d;
            strip_ct_q  <= strip_ct_d;
            wr_ct_q     <= wr_ct_d;
            rd_addr_q   <= rd_addr_d;
            iss_q       <= iss_d;
            iss_ct_q    <= iss_ct_d;
            rd_vld_q    <= rd_vld_d;
            cons_ct_q   <= cons_ct_d;
            surv_q      <= surv_d;
            lfsr_q      <= lfsr_d;
            paying_q    <= paying_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign found_idx   = found_idx_q;
    assign err_nomatch = err_q;
    assign ambig       = ambig_q;
    assign strip_ct    = strip_ct_q;
    assign wr_ct       = wr_ct_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Bench for lfsr_stream_decrypt: table of runs plus reset / restart / FIN-start sequences,
// with expected writes queued from a plaintext golden model and popped on wr_en.
module tb_lfsr_stream_decrypt;

    localparam int         MSG_LEN = 64;
    localparam int         PRE_LEN = 7;
    localparam int         SRC     = 64;
    localparam int         DST     = 0;
    localparam logic [7:0] PRE     = 8'h5F;
    localparam logic [35:0] TAPS   = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21};

    localparam int K_HELLO = 0, K_RAND = 1, K_ALLPRE = 2, K_EMBED = 3, K_NOMATCH = 4;

    typedef struct {
        int         tap;
        logic [5:0] seed;
        bit         rs;
        int         pre;
        int         kind;
        int         e_idx;
        int         e_strip;
        int         e_wr;
        int         e_err;
        int         e_amb;
        int         e_done;
    } vec_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       init_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rd_addr, rd_data, wr_addr, wr_data, strip_ct, wr_ct;
    logic       wr_en, busy, done, err_nomatch, ambig;
    logic [5:0] found;
    logic [2:0] found_idx;

    logic [7:0] mem     [256];
    logic [7:0] dst_mem [256];
    wr_t        exp_q   [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    lfsr_stream_decrypt dut (
        .clk(clk), .init_n(init_n), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .found(found), .found_idx(found_idx),
        .err_nomatch(err_nomatch), .ambig(ambig), .strip_ct(strip_ct), .wr_ct(wr_ct)
    );

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) dst_mem[wr_addr] <= wr_data;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [5:0] tstep(input logic [5:0] s, input int t);
        logic [5:0] tp;
        tp = TAPS[t*6 +: 6];
        return {s[4:0], ^(s & tp)};
    endfunction

    // True when no other candidate reproduces the keystream over the training window.
    function automatic bit uniq(input int tap, input logic [5:0] seed);
        for (int c = 0; c < 6; c++) begin
            if (c != tap) begin
                logic [5:0] a, b;
                bit same;
                a = seed; b = seed; same = 1'b1;
                for (int k = 1; k < PRE_LEN; k++) begin
                    a = tstep(a, tap);
                    b = tstep(b, c);
                    if (a != b) same = 1'b0;
                end
                if (same) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [5:0] pick_seed(input int tap);
        logic [5:0] s;
        s = 6'(($urandom_range(1, 63)));
        for (int n = 0; n < 1000 && !uniq(tap, s); n++) s = 6'($urandom_range(1, 63));
        return s;
    endfunction

    task automatic build(input vec_t v);
        logic [7:0]  p [MSG_LEN];
        logic [5:0]  s;
        logic [39:0] hello;
        bit          started;
        int          w;
        hello = "Hello";
        exp_q.delete();
        for (int k = 0; k < MSG_LEN; k++) p[k] = (k < v.pre) ? PRE : 8'($urandom_range(0, 255));
        case (v.kind)
            K_HELLO:  for (int i = 0; i < 5; i++) p[v.pre + i] = hello[39 - 8*i -: 8];
            K_RAND:   if (p[v.pre] == PRE) p[v.pre] = 8'h41;
            K_ALLPRE: for (int k = 0; k < MSG_LEN; k++) p[k] = PRE;
            K_EMBED: begin
                p[v.pre] = 8'h41; p[v.pre + 3] = PRE; p[v.pre + 4] = PRE;
                p[v.pre + 9] = PRE; p[MSG_LEN - 1] = PRE;
            end
            default: ;
        endcase
        s = v.seed;
        for (int k = 0; k < MSG_LEN; k++) begin
            mem[SRC + k] = p[k] ^ {2'b00, s};
            s = tstep(s, v.tap);
        end
        if (v.kind == K_NOMATCH) begin
            s = {v.seed[4:0] ^ 5'h01, 1'b0};
            mem[SRC + 1] = PRE ^ {2'b00, s};
        end else begin
            started = 1'b0; w = 0;
            for (int k = 0; k < MSG_LEN; k++) begin
                if (started || p[k] != PRE) begin
                    started = 1'b1;
                    exp_q.push_back('{addr: 8'(DST + w), data: p[k]});
                    w++;
                end
            end
        end
    endtask

    task automatic run_one(input vec_t v, input string tag, input int restart_cyc,
                           input int abort_cyc, input bit fin_start);
        int  cyc, done_cyc;
        bit  got_done;
        wr_t e;
        build(v);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 1; got_done = 1'b0; done_cyc = -1;
        while (cyc <= 150) begin
            if (cyc == abort_cyc) begin
                chk("wr_en_before_rst", int'(wr_en), 1);
                #2 init_n = 1'b0;
                #1;
                chk("rst_wr_en", int'(wr_en), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_found", int'(found), 0);
                chk("rst_wr_ct", int'(wr_ct), 0);
                chk("rst_strip_ct", int'(strip_ct), 0);
                @(negedge clk); init_n = 1'b1;
                exp_q.delete();
                $display("run %s: reset asserted at cycle %0d", tag, cyc);
                return;
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", int'(wr_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), int'(e.addr));
                    chk("wr_data", int'(wr_data), int'(e.data));
                end
            end
            start = (cyc == restart_cyc);
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!got_done) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("done_cycle", done_cyc, v.e_done);
        chk("busy_at_done", int'(busy), 0);
        chk("found", int'(found), v.e_err ? 0 : (1 << v.e_idx));
        chk("found_idx", int'(found_idx), v.e_idx);
        chk("err_nomatch", int'(err_nomatch), v.e_err);
        chk("ambig", int'(ambig), v.e_amb);
        chk("strip_ct", int'(strip_ct), v.e_strip);
        chk("wr_ct", int'(wr_ct), v.e_wr);
        chk("pending_writes", exp_q.size(), 0);
        $display("run %s: tap=%0d seed=%h pre=%0d found=%b idx=%0d err=%0d amb=%0d strip=%0d wr=%0d done@%0d",
                 tag, v.tap, v.seed, v.pre, found, found_idx, err_nomatch, ambig, strip_ct, wr_ct, done_cyc);
        if (fin_start) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after_fin", int'(busy), 0);
        chk("hold_found_idx", int'(found_idx), v.e_idx);
        chk("hold_wr_ct", int'(wr_ct), v.e_wr);
        @(posedge clk); #1;
        chk("idle_stays_idle", int'(busy), 0);
    endtask

    initial begin
        vec_t        vt [11];
        logic [39:0] hello;
        hello = "Hello";
        vt[0] = '{3, 6'h0A, 1'b0, 10, K_HELLO, 3, 10, 54, 0, 0, 67};
        for (int c = 0; c < 6; c++)
            vt[1 + c] = '{c, 6'h00, 1'b1, 7 + c, K_RAND, c, 7 + c, MSG_LEN - 7 - c, 0, 0, 67};
        vt[7]  = '{2, 6'h00, 1'b1, 7, K_ALLPRE, 2, 64, 0, 0, 0, 67};
        vt[8]  = '{1, 6'h00, 1'b1, 8, K_EMBED, 1, 8, 56, 0, 0, 67};
        vt[9]  = '{4, 6'h15, 1'b0, 7, K_NOMATCH, 0, 0, 0, 1, 0, 9};
        vt[10] = '{5, 6'h00, 1'b0, 9, K_RAND, 0, 9, 55, 0, 1, 67};
        for (int i = 0; i < 11; i++) if (vt[i].rs) vt[i].seed = pick_seed(vt[i].tap);
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_found", int'(found), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        @(negedge clk); init_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_strip_ct", int'(strip_ct), 0);

        for (int i = 0; i < 11; i++) begin
            run_one(vt[i], $sformatf("vec%0d", i), -1, -1, 1'b0);
            if (i == 0)
                for (int j = 0; j < 5; j++) chk("hello_mem", int'(dst_mem[DST + j]), int'(hello[39 - 8*j -: 8]));
        end

        run_one(vt[1], "restart_mid_run", 20, -1, 1'b0);
        run_one(vt[2], "start_in_fin", -1, -1, 1'b1);
        run_one(vt[0], "reset_mid_run", -1, 30, 1'b0);
        run_one(vt[0], "after_reset", -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
